// File: rtl/hit_serializer_pkg.sv
// Shared constants, the buffered hit entry type, and a saturating counter helper
// for the hit serializer.
package hit_serializer_pkg;
  localparam int SIGFIG  = 24;
  localparam int RADIX   = 10;
  localparam int AXIS    = 3;
  localparam int COLORS  = 3;
  localparam int SAMPLES = 4;
  localparam int DEPTH   = 16;

  typedef struct packed {
    logic signed [AXIS-1:0][SIGFIG-1:0] pos;
    logic        [COLORS-1:0][SIGFIG-1:0] color;
  } pix_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction
endpackage

// File: rtl/hit_serializer_if.sv
// Valid/ready pixel stream from the hit serializer toward the frame-buffer writer.
interface hit_serializer_if #(
  parameter int SIGFIG = hit_serializer_pkg::SIGFIG,
  parameter int AXIS   = hit_serializer_pkg::AXIS,
  parameter int COLORS = hit_serializer_pkg::COLORS
);
  logic                           pix_valid;
  logic                           pix_ready;
  logic [AXIS-1:0][SIGFIG-1:0]    pix_S;
  logic [COLORS-1:0][SIGFIG-1:0]  pix_color_U;

  modport master (output pix_valid, output pix_S, output pix_color_U, input  pix_ready);
  modport slave  (input  pix_valid, input  pix_S, input  pix_color_U, output pix_ready);
endinterface

// File: rtl/hit_serializer_compact.sv
// Hit-lane compaction: total hit count and each lane's slot offset within the group.
module hit_compact #(
  parameter  int SAMPLES = hit_serializer_pkg::SAMPLES,
  localparam int KW      = $clog2(SAMPLES+1)
) (
  input  logic [SAMPLES-1:0]          hit_valid_R18H,
  output logic [KW-1:0]               k,
  output logic [SAMPLES-1:0][KW-1:0]  offs
);
  logic [KW-1:0] acc;

  // Exclusive prefix popcount: a lane's offset is the number of valid lanes below it.
  always_comb begin
    offs = '0;
    acc  = '0;
    for (int l = 0; l < SAMPLES; l++) begin
      offs[l] = acc;
      acc     = acc + KW'(hit_valid_R18H[l]);
    end
    k = acc;
  end
endmodule

// File: rtl/hit_serializer.sv
// Buffers each cycle's group of rast hits into a multi-write circular FIFO and drains
// them one per cycle; groups that do not fit are dropped whole and counted.
module hit_serializer import hit_serializer_pkg::*; #(
  parameter  int SIGFIG  = hit_serializer_pkg::SIGFIG,
  parameter  int AXIS    = hit_serializer_pkg::AXIS,
  parameter  int COLORS  = hit_serializer_pkg::COLORS,
  parameter  int SAMPLES = hit_serializer_pkg::SAMPLES,
  parameter  int DEPTH   = hit_serializer_pkg::DEPTH,
  localparam int CW      = $clog2(DEPTH)+1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [SAMPLES-1:0][AXIS-1:0][SIGFIG-1:0]  hit_R18S,
  input  logic [COLORS-1:0][SIGFIG-1:0]             color_R18U,
  input  logic [SAMPLES-1:0]                        hit_valid_R18H,
  hit_serializer_if.master                          pix,
  output logic [CW-1:0]                             fifo_count,
  output logic                                      overflow,
  output logic [15:0]                               drop_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int KW = $clog2(SAMPLES+1);
  localparam int EW = (AXIS+COLORS)*SIGFIG;

  logic [EW-1:0]              mem [DEPTH];
  logic [PW-1:0]              wr_ptr, rd_ptr;
  logic [KW-1:0]              k, pushed;
  logic [SAMPLES-1:0][KW-1:0] offs;
  logic [CW:0]                free;
  logic                       pop, push_ok;

  hit_compact #(.SAMPLES(SAMPLES)) u_compact (
    .hit_valid_R18H (hit_valid_R18H),
    .k              (k),
    .offs           (offs)
  );

  assign pix.pix_valid = (fifo_count != '0);
  assign {pix.pix_S, pix.pix_color_U} = pix.pix_valid ? mem[rd_ptr] : '0;

  // Pop-before-push: the slot vacated by this cycle's pop is available to the push.
  always_comb begin
    pop     = pix.pix_valid & pix.pix_ready;
    free    = (CW+1)'(DEPTH) - (CW+1)'(fifo_count) + (CW+1)'(pop);
    push_ok = ((CW+1)'(k) <= free);
    pushed  = push_ok ? k : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      wr_ptr     <= wr_ptr + PW'(pushed);
      fifo_count <= fifo_count + CW'(pushed) - CW'(pop);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (!push_ok) begin
        overflow <= 1'b1;
        drop_cnt <= sat_add16(drop_cnt, 16'(k));
      end
    end
  end

  // Compacted scatter; index arithmetic wraps naturally at DEPTH-1 -> 0.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      for (int l = 0; l < SAMPLES; l++)
        if (hit_valid_R18H[l])
          mem[wr_ptr + PW'(offs[l])] <= {hit_R18S[l], color_R18U};
    end
  end
endmodule

// File: doc/hit_serializer.md
# hit_serializer

Downstream of `rast`, this block accepts the per-cycle group of up to SAMPLES sample hits at stage R18 and buffers each valid hit as one entry in a multi-write circular FIFO. It then drains the entries one per cycle over a valid/ready stream toward the frame-buffer writer. `rast` cannot be back-pressured, so any group that does not fit is dropped whole and flagged.

## Interface
Parameters:
- SIGFIG, 24, bits in position and color
- RADIX, 10, fraction bits (carried through, not interpreted)
- AXIS, 3, axes per hit (x,y,z)
- COLORS, 3, color channels
- SAMPLES, 4, parallel hit lanes from `rast`
- DEPTH, 16, FIFO entries; power of 2, ≥ 2·SAMPLES

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- hit_R18S  in  [SAMPLES][AXIS]×SIGFIG signed  hit locations
- color_R18U  in  [COLORS]×SIGFIG unsigned  triangle color, shared by the group
- hit_valid_R18H  in  [SAMPLES]×1  per-lane hit flag
- pix_valid  out  1  head entry available
- pix_ready  in  1  consumer accepts head
- pix_S  out  [AXIS]×SIGFIG signed  head hit location
- pix_color_U  out  [COLORS]×SIGFIG unsigned  head color
- fifo_count  out  $clog2(DEPTH)+1  occupied entries
- overflow  out  1  sticky: a group has been dropped
- drop_cnt  out  16  hits dropped, saturating at 0xFFFF

## Operation
- Each cycle, k = popcount(hit_valid_R18H), range 0..SAMPLES.
- pop = pix_valid & pix_ready.
- free = DEPTH − fifo_count + pop. Pop-before-push: a slot freed this cycle is usable by the same cycle's push.
- If k ≤ free, push all k hits.
  - Hits are written in ascending lane order, compacted with no gaps.
  - Entry j goes to (wr_ptr + j) mod DEPTH.
  - Each entry stores {hit_R18S[lane], color_R18U}.
  - wr_ptr advances by k.
- If k > free, push nothing, set overflow, and add k to drop_cnt (saturating). Partial groups are never written.
- k = 0 is a no-op push.
- On pop, rd_ptr advances by 1 mod DEPTH.
- fifo_count_next = fifo_count + pushed − pop. It never exceeds DEPTH and never underflows.
- pix_valid = (fifo_count ≠ 0). pix_S and pix_color_U present the head entry (first-word-fall-through).
- pix_S and pix_color_U are don't-care when pix_valid = 0.
- Stream rule: once pix_valid is asserted, the head entry is stable until it is accepted. Payload changes only after a pop.
- overflow clears only on rst.

## Timing
- Reset values: wr_ptr = 0, rd_ptr = 0, fifo_count = 0, pix_valid = 0, overflow = 0, drop_cnt = 0. pix_S and pix_color_U reset to 0.
- Reset mid-operation discards all buffered entries. Hits presented in the same cycle as rst are not stored.
- Latency: a hit presented at edge N is visible on pix_valid/pix_S after edge N (usable in cycle N+1) when the FIFO was empty.
- Throughput: 1 pop per cycle, up to SAMPLES pushes per cycle.
- Wrap-around: a multi-entry push may straddle index DEPTH−1 → 0 in a single cycle.
- Full FIFO with a simultaneous pop and a 1-hit group: the push is accepted and fifo_count stays at DEPTH.
- Empty FIFO with pix_ready held high: no pop occurs and the pointers do not move.
- drop_cnt and overflow update at the same edge as the rejected group.

## Structure
- rast_params gains:
  - the DEPTH constant;
  - typedef `pix_t`, a packed struct {signed pos[AXIS], unsigned color[COLORS]} of SIGFIG-bit fields.
- Sub-module `hit_compact` (combinational):
  - inputs: hit_valid_R18H;
  - outputs: k and a per-lane write offset (prefix popcount).
- The FIFO array, pointers, counters and flags live in `hit_serializer`.
- Storage is a register array; there is no SRAM macro at this depth.

## Test plan
- Reset, then present hit_valid = 4'b0101 with hit lanes 0 and 2 at (1,2,3) and (4,5,6). With pix_ready = 1: pix_S = (1,2,3) in cycle 1, then (4,5,6) in cycle 2, then pix_valid = 0.
- Hold pix_ready = 0 and present four 4-hit groups. fifo_count reaches 16 and overflow stays 0. A fifth group (k = 4) is dropped: drop_cnt = 4, overflow = 1, fifo_count stays 16.
- With the FIFO full, pix_ready = 1 and a 1-hit group in the same cycle: the group is accepted and fifo_count stays 16.
- With wr_ptr = 14, push a 4-hit group. Entries land at 14, 15, 0, 1 and drain in lane order 0..3.
- Toggle pix_ready pseudo-randomly under random hit patterns. The drained sequence must equal the pushed sequence in order, and payload must hold stable while pix_valid = 1 and pix_ready = 0.
- Assert rst with fifo_count = 9 and overflow = 1. The next cycle shows fifo_count = 0, pix_valid = 0, overflow = 0 and drop_cnt = 0.
